buffer_exmem_pipe: RTL and testbench

BUFFER_EXMEM_PIPE -- requirements
Module: buffer_exmem_pipe

---
 rtl/exmem_pkg.sv | 25 ++
 rtl/sat_counter.sv | 21 ++
 rtl/buffer_exmem_pipe.sv | 95 +++++++++
 tb/tb_buffer_exmem_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exmem_pkg.sv
// Shared definitions for the EX/MEM pipeline buffer: control-bit positions,
// default widths and the redirect decision.
package exmem_pkg;

  localparam int CTRL_W = 6;

  localparam int JUMP       = 5;
  localparam int REG_WRITE  = 4;
  localparam int MEM_TO_REG = 3;
  localparam int MEM_WRITE  = 2;
  localparam int MEM_READ   = 1;
  localparam int BRANCH     = 0;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;
  localparam int CNT_W_DEF  = 16;

  typedef logic [CTRL_W-1:0] ctrl_t;

  // Jumps always redirect; branches redirect only when the ALU reports equality.
  function automatic logic pc_src_of(input ctrl_t ctrl, input logic zero);
    return (ctrl[BRANCH] && zero) || ctrl[JUMP];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/buffer_exmem_pipe.sv
// EX/MEM pipeline register with valid/ready handshake, flush, redirect
// resolution and a saturating back-pressure counter.
module buffer_exmem_pipe
  import exmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_zero,
  input  logic [DATA_W-1:0] in_branch_target,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [DATA_W-1:0] in_jump_target,
  input  logic [REG_W-1:0]  in_dest_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_dest_reg,
  output logic              out_pc_src,
  output logic [DATA_W-1:0] out_redirect_pc,
  output logic [CNT_W-1:0]  stall_count
);

  logic              load;
  logic              valid_q;
  ctrl_t             ctrl_in;
  ctrl_t             ctrl_q;
  logic              pc_src_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] store_q;
  logic [REG_W-1:0]  dest_q;
  logic [DATA_W-1:0] redirect_q;

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // NOTE: assigning the default before the conditional override keeps
  // this combinational block from inferring a latch.
  always_comb begin
    ctrl_in = in_ctrl;
    if (in_dest_reg == '0) ctrl_in[REG_WRITE] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_src_q   <= 1'b0;
      alu_q      <= '0;
      store_q    <= '0;
      dest_q     <= '0;
      redirect_q <= '0;
    end else begin
      // Flush beats load; a consumed entry with nothing behind it empties the slot.
      if (flush)          valid_q <= 1'b0;
      else if (load)      valid_q <= 1'b1;
      else if (out_ready) valid_q <= 1'b0;

      if (load) begin
        ctrl_q     <= ctrl_in;
        pc_src_q   <= pc_src_of(in_ctrl, in_zero);
        alu_q      <= in_alu_result;
        store_q    <= in_store_data;
        dest_q     <= in_dest_reg;
        redirect_q <= in_ctrl[JUMP] ? in_jump_target : in_branch_target;
      end
    end
  end

  // Control outputs are gated so an empty slot can never issue side effects.
  assign out_valid       = valid_q;
  assign out_ctrl        = valid_q ? ctrl_q : '0;
  assign out_pc_src      = valid_q && pc_src_q;
  assign out_alu_result  = alu_q;
  assign out_store_data  = store_q;
  assign out_dest_reg    = dest_q;
  assign out_redirect_pc = redirect_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (valid_q && !out_ready),
    .count (stall_count)
  );

endmodule

// File: tb/tb_buffer_exmem_pipe.sv
// Self-checking bench for buffer_exmem_pipe: directed vector table, hand-written
// stall/flush/reset sequences and randomized traffic against a reference model.
module tb_buffer_exmem_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, out_ready, in_zero;
  logic [5:0]  in_ctrl;
  logic [31:0] in_branch_target, in_alu_result, in_store_data, in_jump_target;
  logic [4:0]  in_dest_reg;

  logic        in_ready, out_valid, out_pc_src;
  logic [5:0]  out_ctrl;
  logic [31:0] out_alu_result, out_store_data, out_redirect_pc;
  logic [4:0]  out_dest_reg;
  logic [15:0] stall_count;

  logic        c2_in_ready, c2_out_valid, c2_out_pc_src;
  logic [5:0]  c2_out_ctrl;
  logic [31:0] c2_out_alu_result, c2_out_store_data, c2_out_redirect_pc;
  logic [4:0]  c2_out_dest_reg;
  logic [1:0]  c2_stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  buffer_exmem_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_zero(in_zero), .in_branch_target(in_branch_target),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_jump_target(in_jump_target), .in_dest_reg(in_dest_reg),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_dest_reg(out_dest_reg), .out_pc_src(out_pc_src),
    .out_redirect_pc(out_redirect_pc), .stall_count(stall_count)
  );

  buffer_exmem_pipe #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c2_in_ready),
    .in_ctrl(in_ctrl), .in_zero(in_zero), .in_branch_target(in_branch_target),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_jump_target(in_jump_target), .in_dest_reg(in_dest_reg),
    .out_valid(c2_out_valid), .out_ready(out_ready), .out_ctrl(c2_out_ctrl),
    .out_alu_result(c2_out_alu_result), .out_store_data(c2_out_store_data),
    .out_dest_reg(c2_out_dest_reg), .out_pc_src(c2_out_pc_src),
    .out_redirect_pc(c2_out_redirect_pc), .stall_count(c2_stall_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: one slot holding the last accepted entry.
  typedef struct {
    logic [5:0]  ctrl;
    logic [31:0] alu, sd, redir;
    logic [4:0]  dest;
    logic        pc_src;
  } entry_t;

  logic   m_valid;
  entry_t m_e;
  int     m_stall, m_stall2;

  task automatic model_reset();
    m_valid  = 1'b0;
    m_e      = '{ctrl: 6'd0, alu: 32'd0, sd: 32'd0, redir: 32'd0, dest: 5'd0, pc_src: 1'b0};
    m_stall  = 0;
    m_stall2 = 0;
  endtask

  // Evaluates the slot rules on the current inputs, then advances one clock.
  task automatic step();
    logic   nv;
    entry_t ne;
    int     ns, ns2;
    logic   accept;
    nv  = m_valid;
    ne  = m_e;
    ns  = m_stall;
    ns2 = m_stall2;
    accept = in_valid && (!m_valid || out_ready) && !flush;
    if (m_valid && !out_ready) begin
      ns  = (m_stall  < 65535) ? m_stall  + 1 : 65535;
      ns2 = (m_stall2 < 3)     ? m_stall2 + 1 : 3;
    end
    if (accept) begin
      ne.ctrl   = in_ctrl;
      if (in_dest_reg == 0) ne.ctrl[4] = 1'b0;
      ne.alu    = in_alu_result;
      ne.sd     = in_store_data;
      ne.dest   = in_dest_reg;
      ne.pc_src = (in_ctrl[0] && in_zero) || in_ctrl[5];
      ne.redir  = in_ctrl[5] ? in_jump_target : in_branch_target;
    end
    if (flush)          nv = 1'b0;
    else if (accept)    nv = 1'b1;
    else if (out_ready) nv = 1'b0;
    @(posedge clk);
    m_valid  = nv;
    m_e      = ne;
    m_stall  = ns;
    m_stall2 = ns2;
    #1;
  endtask

  task automatic check_model(input int cyc);
    check($sformatf("rnd%0d valid", cyc), out_valid, m_valid);
    check($sformatf("rnd%0d c2_valid", cyc), c2_out_valid, m_valid);
    check($sformatf("rnd%0d ctrl", cyc), out_ctrl, m_valid ? m_e.ctrl : 6'd0);
    check($sformatf("rnd%0d pc_src", cyc), out_pc_src, m_valid && m_e.pc_src);
    check($sformatf("rnd%0d in_ready", cyc), in_ready, !m_valid || out_ready);
    check($sformatf("rnd%0d stall", cyc), stall_count, m_stall);
    check($sformatf("rnd%0d c2_stall", cyc), c2_stall_count, m_stall2);
    if (m_valid) begin
      check($sformatf("rnd%0d alu", cyc), out_alu_result, m_e.alu);
      check($sformatf("rnd%0d sd", cyc), out_store_data, m_e.sd);
      check($sformatf("rnd%0d dest", cyc), out_dest_reg, m_e.dest);
      check($sformatf("rnd%0d redir", cyc), out_redirect_pc, m_e.redir);
    end
  endtask

  task automatic drive(input logic f, input logic v, input logic r, input logic [5:0] c,
                       input logic z, input logic [31:0] bt, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [31:0] jt, input logic [4:0] d);
    flush = f; in_valid = v; out_ready = r; in_ctrl = c; in_zero = z;
    in_branch_target = bt; in_alu_result = alu; in_store_data = sd;
    in_jump_target = jt; in_dest_reg = d;
  endtask

  typedef struct {
    logic        f, v, r;
    logic [5:0]  ctrl;
    logic        z;
    logic [31:0] bt, alu, sd, jt;
    logic [4:0]  dest;
    logic        e_valid;
    logic [5:0]  e_ctrl;
    logic        e_pc;
    logic [31:0] e_redir, e_alu, e_sd;
    logic [4:0]  e_dest;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b1, 6'b010000, 1'b0, 32'h0,  32'h10, 32'hAA, 32'h0,  5'd3,
                1'b1, 6'b010000, 1'b0, 32'h0,  32'h10, 32'hAA, 5'd3};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 6'b000001, 1'b1, 32'h40, 32'h20, 32'hBB, 32'h0,  5'd4,
                1'b1, 6'b000001, 1'b1, 32'h40, 32'h20, 32'hBB, 5'd4};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 6'b100000, 1'b0, 32'h40, 32'h30, 32'hCC, 32'h80, 5'd0,
                1'b1, 6'b100000, 1'b1, 32'h80, 32'h30, 32'hCC, 5'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 6'b100001, 1'b1, 32'h40, 32'h34, 32'hCD, 32'h80, 5'd7,
                1'b1, 6'b100001, 1'b1, 32'h80, 32'h34, 32'hCD, 5'd7};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 6'b010000, 1'b0, 32'h0,  32'h50, 32'hDD, 32'h0,  5'd0,
                1'b1, 6'b000000, 1'b0, 32'h0,  32'h50, 32'hDD, 5'd0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 6'b011011, 1'b0, 32'h44, 32'h60, 32'hEE, 32'h90, 5'd9,
                1'b1, 6'b011011, 1'b0, 32'h44, 32'h60, 32'hEE, 5'd9};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 6'b010000, 1'b1, 32'h0,  32'h70, 32'h0,  32'h0,  5'd3,
                1'b0, 6'b000000, 1'b0, 32'h0,  32'h0,  32'h0,  5'd0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 6'b110001, 1'b1, 32'h0,  32'h74, 32'h0,  32'h0,  5'd3,
                1'b0, 6'b000000, 1'b0, 32'h0,  32'h0,  32'h0,  5'd0};

    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 6'b111111, 1'b1, 32'h1, 32'h2, 32'h3, 32'h4, 5'd5);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", out_valid, 1'b0);
    check("rst in_ready", in_ready, 1'b1);
    check("rst out_ctrl", out_ctrl, 6'd0);
    check("rst out_pc_src", out_pc_src, 1'b0);
    check("rst out_alu", out_alu_result, 32'd0);
    check("rst out_redir", out_redirect_pc, 32'd0);
    check("rst stall", stall_count, 16'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].f, vecs[i].v, vecs[i].r, vecs[i].ctrl, vecs[i].z,
            vecs[i].bt, vecs[i].alu, vecs[i].sd, vecs[i].jt, vecs[i].dest);
      step();
      check($sformatf("vec%0d valid", i), out_valid, vecs[i].e_valid);
      check($sformatf("vec%0d ctrl", i), out_ctrl, vecs[i].e_ctrl);
      check($sformatf("vec%0d pc_src", i), out_pc_src, vecs[i].e_pc);
      check($sformatf("vec%0d stall", i), stall_count, 16'd0);
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d redir", i), out_redirect_pc, vecs[i].e_redir);
        check($sformatf("vec%0d alu", i), out_alu_result, vecs[i].e_alu);
        check($sformatf("vec%0d sd", i), out_store_data, vecs[i].e_sd);
        check($sformatf("vec%0d dest", i), out_dest_reg, vecs[i].e_dest);
      end
    end

    // Back-pressure: entry A held for five cycles while B waits.
    drive(1'b0, 1'b1, 1'b1, 6'b010000, 1'b0, 32'h0, 32'hA0A0, 32'h1, 32'h0, 5'd1);
    step();
    drive(1'b0, 1'b1, 1'b0, 6'b010100, 1'b0, 32'h0, 32'hB0B0, 32'h2, 32'h0, 5'd2);
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("hold%0d alu", i), out_alu_result, 32'hA0A0);
      check($sformatf("hold%0d in_ready", i), in_ready, 1'b0);
      check($sformatf("hold%0d valid", i), out_valid, 1'b1);
      check($sformatf("hold%0d stall", i), stall_count, i);
    end
    out_ready = 1'b1;
    #1;
    check("release in_ready", in_ready, 1'b1);
    step();
    check("release alu", out_alu_result, 32'hB0B0);
    check("release ctrl", out_ctrl, 6'b010100);
    check("release stall", stall_count, 16'd5);

    // Flush wins over a simultaneous load.
    drive(1'b1, 1'b1, 1'b1, 6'b110011, 1'b1, 32'h0, 32'hC0C0, 32'h0, 32'h0, 5'd6);
    step();
    check("flush valid", out_valid, 1'b0);
    check("flush ctrl", out_ctrl, 6'd0);
    check("flush pc_src", out_pc_src, 1'b0);
    check("flush stall", stall_count, 16'd5);
    drive(1'b0, 1'b1, 1'b1, 6'b010000, 1'b0, 32'h0, 32'hD0D0, 32'h0, 32'h0, 5'd6);
    step();
    drive(1'b1, 1'b0, 1'b0, 6'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    step();
    check("flush_stalled valid", out_valid, 1'b0);
    check("flush_stalled stall", stall_count, 16'd6);

    // Asynchronous reset discards a stalled entry immediately.
    drive(1'b0, 1'b1, 1'b1, 6'b010000, 1'b0, 32'h0, 32'hE0E0, 32'h0, 32'h0, 5'd4);
    step();
    out_ready = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst valid", out_valid, 1'b0);
    check("async_rst in_ready", in_ready, 1'b1);
    check("async_rst ctrl", out_ctrl, 6'd0);
    check("async_rst alu", out_alu_result, 32'd0);
    check("async_rst stall", stall_count, 16'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 6'b010000, 1'b0, 32'h0, 32'hF0F0, 32'h0, 32'h0, 5'd8);
    step();
    check("post_rst valid", out_valid, 1'b1);
    check("post_rst alu", out_alu_result, 32'hF0F0);

    // Six stall cycles: the 2-bit counter sticks at 3.
    drive(1'b0, 1'b0, 1'b0, 6'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 3 || i == 4) check($sformatf("sat%0d c2_stall", i), c2_stall_count, 2'd3);
    end
    check("sat c2_stall", c2_stall_count, 2'd3);
    check("sat stall", stall_count, 16'd6);

    for (int cyc = 0; cyc < 400; cyc++) begin
      flush            = ($urandom_range(0, 9) == 0);
      in_valid         = ($urandom_range(0, 3) != 0);
      out_ready        = ($urandom_range(0, 9) < 7);
      in_ctrl          = 6'($urandom_range(0, 63));
      in_zero          = 1'($urandom_range(0, 1));
      in_branch_target = $urandom;
      in_alu_result    = $urandom;
      in_store_data    = $urandom;
      in_jump_target   = $urandom;
      in_dest_reg      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      step();
      check_model(cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
